// File: rtl/pc_gen.sv
// Fetch program-counter generator: prioritised next-PC select, stall, alignment flag and an
// optional return-address stack that is built only when the PC_RAS_EN macro is defined.
module pc_gen #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              RAS_DEPTH    = 4
) (
    input  logic            clk,
    input  logic            areset,
    input  logic            stall,
    input  logic            flush_valid,
    input  logic [XLEN-1:0] flush_target,
    input  logic            jump_valid,
    input  logic [XLEN-1:0] jump_target,
    input  logic            call,
    input  logic            ret_valid,
    input  logic [XLEN-1:0] ret_target,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    output logic [XLEN-1:0] PC,
    output logic [XLEN-1:0] PCPlus4,
    output logic            misaligned,
    output logic            ras_empty
);

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pcplus4;
    logic [XLEN-1:0] raw_tgt;
    logic [XLEN-1:0] ret_sel;
    logic            mis_q, mis_d;
    logic            tgt_sel;
    logic            upd;

    assign pcplus4 = pc_q + {{(XLEN-3){1'b0}}, 3'd4};
    assign upd     = flush_valid | ~stall;

`ifdef PC_RAS_EN
    localparam int PW = $clog2(RAS_DEPTH);
    localparam logic [PW:0] RAS_FULL = RAS_DEPTH[PW:0];

    logic [XLEN-1:0] ras_q [RAS_DEPTH];
    logic [PW-1:0]   tp_q, tp_d;
    logic [PW:0]     cnt_q, cnt_d;
    logic [PW-1:0]   ras_wr_idx;
    logic            ras_we;
    logic            push, pop, replace, empty;

    assign empty   = (cnt_q == '0);
    assign ret_sel = empty ? ret_target : ras_q[tp_q];
    // Flushes and stalled cycles never touch the stack.
    assign push    = upd & ~flush_valid & jump_valid & call;
    assign pop     = upd & ~flush_valid & ret_valid & ~jump_valid & ~empty;
    assign replace = push & ret_valid & ~empty;

    always_comb begin
        tp_d       = tp_q;
        cnt_d      = cnt_q;
        ras_we     = 1'b0;
        ras_wr_idx = tp_q;
        if (replace) begin
            ras_we = 1'b1;
        end else if (push) begin
            // Circular buffer: a push while full silently overwrites the oldest entry.
            tp_d       = tp_q + 1'b1;
            ras_wr_idx = tp_q + 1'b1;
            ras_we     = 1'b1;
            cnt_d      = (cnt_q == RAS_FULL) ? cnt_q : cnt_q + 1'b1;
        end else if (pop) begin
            tp_d  = tp_q - 1'b1;
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (areset) begin
            tp_q  <= '0;
            cnt_q <= '0;
        end else begin
            tp_q  <= tp_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (ras_we) begin
            ras_q[ras_wr_idx] <= pcplus4;
        end
    end

    assign ras_empty = empty;
`else
    logic unused_cfg;

    assign unused_cfg = ^{call, RAS_DEPTH[0]};
    assign ret_sel    = ret_target;
    assign ras_empty  = 1'b1;
`endif

    always_comb begin
        raw_tgt = pcplus4;
        tgt_sel = 1'b1;
        if (flush_valid) begin
            raw_tgt = flush_target;
        end else if (jump_valid) begin
            raw_tgt = jump_target;
        end else if (ret_valid) begin
            raw_tgt = ret_sel;
        end else if (branch_taken) begin
            raw_tgt = branch_target;
        end else begin
            tgt_sel = 1'b0;
        end
        pc_d  = tgt_sel ? {raw_tgt[XLEN-1:2], 2'b00} : pcplus4;
        mis_d = tgt_sel & (|raw_tgt[1:0]);
    end

    always_ff @(posedge clk) begin
        if (areset) begin
            pc_q  <= RESET_VECTOR;
            mis_q <= 1'b0;
        end else if (upd) begin
            pc_q  <= pc_d;
            mis_q <= mis_d;
        end
    end

    assign PC         = pc_q;
    assign PCPlus4    = pcplus4;
    assign misaligned = mis_q;

endmodule
